// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq execute-stage ALU.
//   - aluop_e : operation encodings (12-15 are illegal; 11 is MULHU only when ALU_MULHU_EN is
//               defined, otherwise it is illegal too)
//   - state_e : control FSM states
//   - XLEN    : datapath width
//   - mul_latency / mul_bits_legal : iterative-multiplier timing helpers
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpSll   = 4'd5,
    OpSrl   = 4'd6,
    OpSra   = 4'd7,
    OpSlt   = 4'd8,
    OpSltu  = 4'd9,
    OpMul   = 4'd10,
    OpMulhu = 4'd11
  } aluop_e;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } state_e;

  // Edges from the accepting edge to the result edge of a MUL.
  function automatic int unsigned mul_latency(input int unsigned bits_per_cycle);
    return XLEN / bits_per_cycle;
  endfunction

  function automatic bit mul_bits_legal(input int unsigned bits_per_cycle);
    return (bits_per_cycle == 1) || (bits_per_cycle == 2) ||
           (bits_per_cycle == 4) || (bits_per_cycle == 8);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result bundle between the pipeline and alu_seq.
//   in_valid/in_ready : issue handshake, aluop/a_bus/b_bus travel with in_valid
//   flush             : pipeline kill
//   out_valid         : one-cycle pulse qualifying result/zero/overflow
// master = pipeline side, slave = ALU side.
interface alu_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [3:0]  aluop;
  logic [31:0] a_bus;
  logic [31:0] b_bus;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  modport master (
    output in_valid,
    output flush,
    output aluop,
    output a_bus,
    output b_bus,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  flush,
    input  aluop,
    input  a_bus,
    input  b_bus,
    output in_ready,
    output out_valid,
    output result,
    output zero,
    output overflow
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring BitsPerCycle multiplier bits per step.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   start_i       : latch a_i/b_i, clear product and counter
//   step_i        : retire one group of multiplier bits
//   clear_i       : abandon the operation (highest priority)
//   prod_next_o   : product including the step being taken this cycle
//   done_o        : the step taken this cycle is the last one
module mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned BitsPerCycle = 1,
  parameter int unsigned ProdW        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             clear_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic [ProdW-1:0] prod_next_o,
  output logic             done_o
);

  localparam int unsigned Latency = mul_latency(BitsPerCycle);
  localparam int unsigned CntW    = 6;

  logic [ProdW-1:0] mcand_q;
  logic [XLEN-1:0]  mplier_q;
  logic [ProdW-1:0] prod_q;
  logic [CntW-1:0]  cnt_q;
  logic [ProdW-1:0] partial;

  // Sum of the multiplicand shifted by each set bit in the low group of the multiplier.
  always_comb begin
    partial = '0;
    for (int i = 0; i < int'(BitsPerCycle); i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end
  end

  assign prod_next_o = prod_q + partial;
  assign done_o      = (cnt_q == CntW'(Latency - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= ProdW'(a_i);
      mplier_q <= b_i;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << BitsPerCycle;
      mplier_q <= mplier_q >> BitsPerCycle;
      prod_q   <= prod_next_o;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU with registered outputs for EX/MEM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_seq_if.slave (issue handshake, flush, operands, registered result/flags)
// Single-cycle ops complete on the accepting edge; MUL (and MULHU) run on mul_iter and hold
// in_ready low until done. Optional feature macro: ALU_MULHU_EN (64-bit product, op 11 MULHU).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  if (!mul_bits_legal(MUL_BITS_PER_CYCLE)) begin : g_bad_mul_bits
    $error("alu_seq: MUL_BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

`ifdef ALU_MULHU_EN
  localparam int unsigned ProdW = 2 * XLEN;
`else
  localparam int unsigned ProdW = XLEN;
`endif

  aluop_e          op;
  logic [31:0]     a;
  logic [31:0]     b;
  logic [4:0]      shamt;
  logic [31:0]     add_res;
  logic [31:0]     sub_res;
  logic [31:0]     alu_res;
  logic            alu_ovf;
  logic            is_mul;
  logic            accept;

  state_e          state_q, state_d;
  logic [31:0]     result_q, result_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;

  logic            mul_start;
  logic            mul_step;
  logic            mul_clear;
  logic            mul_done;
  logic [ProdW-1:0] prod_next;
  logic [31:0]     mul_res;

  assign op      = aluop_e'(bus.aluop);
  assign a       = bus.a_bus;
  assign b       = bus.b_bus;
  assign shamt   = b[4:0];
  assign add_res = a + b;
  assign sub_res = a - b;
  // Flush wins over a simultaneous issue.
  assign accept  = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OpAdd: begin
        alu_res = add_res;
        alu_ovf = (a[31] == b[31]) && (add_res[31] != a[31]);
      end
      OpSub: begin
        alu_res = sub_res;
        alu_ovf = (a[31] != b[31]) && (sub_res[31] != a[31]);
      end
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpSll:  alu_res = a << shamt;
      OpSrl:  alu_res = a >> shamt;
      OpSra:  alu_res = $unsigned($signed(a) >>> shamt);
      OpSlt:  alu_res = {31'b0, $signed(a) < $signed(b)};
      OpSltu: alu_res = {31'b0, a < b};
      default: begin
        // Illegal codes (and MUL codes, which never take this path) yield zero.
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

`ifdef ALU_MULHU_EN
  logic mul_hi_q, mul_hi_d;
  assign is_mul  = (op == OpMul) || (op == OpMulhu);
  assign mul_res = mul_hi_q ? prod_next[63:32] : prod_next[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_hi_q <= 1'b0;
    end else begin
      mul_hi_q <= mul_hi_d;
    end
  end

  always_comb begin
    mul_hi_d = mul_hi_q;
    if (mul_start) begin
      mul_hi_d = (op == OpMulhu);
    end
  end
`else
  assign is_mul  = (op == OpMul);
  assign mul_res = prod_next;
`endif

  mul_iter #(
    .BitsPerCycle(MUL_BITS_PER_CYCLE),
    .ProdW       (ProdW)
  ) u_mul_iter (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (mul_start),
    .step_i     (mul_step),
    .clear_i    (mul_clear),
    .a_i        (a),
    .b_i        (b),
    .prod_next_o(prod_next),
    .done_o     (mul_done)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    mul_start   = 1'b0;
    mul_step    = 1'b0;
    mul_clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = StMul;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (bus.flush) begin
          mul_clear = 1'b1;
          state_d   = StIdle;
        end else begin
          mul_step = 1'b1;
          if (mul_done) begin
            // The final step's product is taken straight from prod_next; the
            // multiplier is cleared on the same edge.
            mul_clear   = 1'b1;
            result_d    = mul_res;
            zero_d      = (mul_res == '0);
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a negedge monitor pops and
// compares whenever out_valid is high.
module tb_alu_seq;

  localparam int unsigned N   = 1;
  localparam int unsigned LAT = 32 / N;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t vecs[$];

  alu_seq_if bus ();

  alu_seq #(
    .MUL_BITS_PER_CYCLE(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    bus.in_valid = v;
    bus.aluop    = op;
    bus.a_bus    = a;
    bus.b_bus    = b;
  endtask

  task automatic expect_out(input logic [31:0] res, input logic z, input logic o);
    exp_t e;
    e.res = res;
    e.z   = z;
    e.o   = o;
    sb.push_back(e);
  endtask

  // Waits for in_ready after a MUL was accepted; returns edges spent busy.
  task automatic wait_ready(output int waits);
    waits = 0;
    while (!bus.in_ready && waits < 200) begin
      waits++;
      tick();
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected out_valid: got result %h expected no output", bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("zero", {31'b0, bus.zero}, {31'b0, e.z});
        chk("overflow", {31'b0, bus.overflow}, {31'b0, e.o});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.flush = 1'b0;
    set_in(1'b0, 4'd0, 32'h0, 32'h0);

    #12;
    chk("reset result", bus.result, 32'h0);
    chk("reset out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("reset zero", {31'b0, bus.zero}, 32'h0);
    chk("reset overflow", {31'b0, bus.overflow}, 32'h0);
    chk("reset in_ready", {31'b0, bus.in_ready}, 32'h1);
    #2;
    rst = 1'b0;
    tick();

    // ADD with signed overflow; out_valid must be a single-cycle pulse.
    set_in(1'b1, 4'd0, 32'h7FFF_FFFF, 32'h1);
    expect_out(32'h8000_0000, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    chk("add out_valid", {31'b0, bus.out_valid}, 32'h1);
    tick();
    chk("add pulse end", {31'b0, bus.out_valid}, 32'h0);

    // SUB then SRA back-to-back (shift amount 36 -> 4).
    set_in(1'b1, 4'd1, 32'h5, 32'h5);
    expect_out(32'h0, 1'b1, 1'b0);
    tick();
    chk("b2b in_ready 1", {31'b0, bus.in_ready}, 32'h1);
    set_in(1'b1, 4'd7, 32'h8000_0000, 32'd36);
    expect_out(32'hF800_0000, 1'b0, 1'b0);
    tick();
    chk("b2b in_ready 2", {31'b0, bus.in_ready}, 32'h1);

    // Remaining single-cycle ops, issued every cycle.
    vecs.push_back({4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0});
    vecs.push_back({4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0});
    vecs.push_back({4'd4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0});
    vecs.push_back({4'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back({4'd6, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back({4'd8, 32'hFFFF_FFFF, 32'h1,         32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back({4'd9, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back({4'd1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1});
    vecs.push_back({4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back({4'd13, 32'h1234_5678, 32'h1,        32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back({4'd0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0});
    foreach (vecs[i]) begin
      set_in(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      expect_out(vecs[i].res, vecs[i].z, vecs[i].o);
      tick();
      chk("table in_ready", {31'b0, bus.in_ready}, 32'h1);
    end
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    tick();

    // MUL with the next op held on in_valid; the ADD must wait for completion.
    set_in(1'b1, 4'd10, 32'hFFFF_FFFF, 32'h3);
    expect_out(32'hFFFF_FFFD, 1'b0, 1'b0);
    expect_out(32'h2, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 4'd0, 32'h1, 32'h1);
    chk("mul in_ready drop", {31'b0, bus.in_ready}, 32'h0);
    wait_ready(waits);
    chk("mul latency", waits, LAT);
    chk("mul out_valid", {31'b0, bus.out_valid}, 32'h1);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    tick();

    // Flush at cycle 10 of a MUL: no output, result kept.
    set_in(1'b1, 4'd10, 32'h7, 32'h6);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("flush out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("flush result", bus.result, 32'h2);
    repeat (40) tick();

    // Flush on the completing edge suppresses out_valid.
    set_in(1'b1, 4'd10, 32'h7, 32'h6);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    repeat (LAT - 1) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("late flush out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("late flush in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("late flush result", bus.result, 32'h2);

    // Flush in IDLE blocks acceptance.
    set_in(1'b1, 4'd0, 32'h9, 32'h9);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    chk("idle flush out_valid", {31'b0, bus.out_valid}, 32'h0);
    tick();
    chk("idle flush result", bus.result, 32'h2);

    // Plain MUL to completion.
    set_in(1'b1, 4'd10, 32'h1234_5678, 32'h10);
    expect_out(32'h2345_6780, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    wait_ready(waits);
    chk("mul2 latency", waits, LAT);
    tick();

    // Asynchronous reset mid-MUL.
    set_in(1'b1, 4'd10, 32'h7, 32'h6);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    repeat (4) tick();
    #1;
    rst = 1'b1;
    #1;
    chk("mid reset result", bus.result, 32'h0);
    chk("mid reset out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("mid reset in_ready", {31'b0, bus.in_ready}, 32'h1);
    #1;
    rst = 1'b0;
    tick();
    set_in(1'b1, 4'd0, 32'h2, 32'h3);
    expect_out(32'h5, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    tick();

    // Op 11.
`ifdef ALU_MULHU_EN
    set_in(1'b1, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_out(32'hFFFF_FFFE, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    wait_ready(waits);
    chk("mulhu latency", waits, LAT);
`else
    set_in(1'b1, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_out(32'h0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 4'd0, 32'h0, 32'h0);
    chk("op11 single-cycle", {31'b0, bus.out_valid}, 32'h1);
    chk("op11 in_ready", {31'b0, bus.in_ready}, 32'h1);
`endif

    repeat (5) tick();
    chk("scoreboard drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
